free_list: RTL



---
 rtl/cpu_params.sv | 13 +
 rtl/free_list_pkg.sv | 6 +
 rtl/free_list_if.sv | 31 +++
 rtl/free_list.sv | 104 ++++++++++
 4 files changed

// File: rtl/cpu_params.sv
// cpu_params: core-wide sizing constants shared by the rename, ROB and
// free-list blocks.
//   PRF_DEPTH / PRF_IDX : physical register count and index width
//   ARF_DEPTH / ARF_IDX : architectural register count and index width
//   FL_DEPTH  / FL_IDX  : free-list entries (PRF - ARF) and slot index width
package cpu_params;
  localparam int PRF_DEPTH = 64;
  localparam int PRF_IDX   = $clog2(PRF_DEPTH);
  localparam int ARF_DEPTH = 32;
  localparam int ARF_IDX   = $clog2(ARF_DEPTH);
  localparam int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH;
  localparam int FL_IDX    = $clog2(FL_DEPTH);
endpackage

// File: rtl/free_list_pkg.sv
// free_list_pkg: types shared between the free list and its neighbours.
//   fl_ptr_t : head/tail pointer, FL_IDX slot bits plus one wrap bit, so a
//              checkpointing ROB can snapshot head directly.
package free_list_pkg;
  typedef logic [cpu_params::FL_IDX:0] fl_ptr_t;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: rename/commit/flush handshake to the physical-register
// free list.
//   dq_en    : rename consumes dq_phy this cycle
//   dq_valid : an index is available
//   dq_phy   : head index offered to rename
//   enq_en   : commit returns enq_phy
//   enq_phy  : stale physical index being freed
//   flush    : recovery pulse from the ROB
//   full     : list holds every free-able index
//   err      : sticky overflow / underflow / x0-free indicator
// master = pipeline side (rename/ROB), slave = free list.
interface free_list_if;
  logic                            dq_en;
  logic                            dq_valid;
  logic [cpu_params::PRF_IDX-1:0]  dq_phy;
  logic                            enq_en;
  logic [cpu_params::PRF_IDX-1:0]  enq_phy;
  logic                            flush;
  logic                            full;
  logic                            err;

  modport master (
    output dq_en, enq_en, enq_phy, flush,
    input  dq_valid, dq_phy, full, err
  );

  modport slave (
    input  dq_en, enq_en, enq_phy, flush,
    output dq_valid, dq_phy, full, err
  );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register indices.
//   clk, rst_n : clock, asynchronous active-low reset
//   fl         : free_list_if.slave (dequeue to rename, enqueue from commit,
//                flush from ROB, full/err status)
// Rename dequeues the head index; commit enqueues the stale mapping at the
// tail. A flush rewinds head to sit one full lap behind tail, which makes
// every slot dequeued since the last commit available again.
// Optional build macro FREE_LIST_BYPASS_EN: when the list is empty a legal
// enqueue is offered on dq_phy in the same cycle and may be consumed
// directly by rename without touching the pointers.
module free_list
  import free_list_pkg::*;
#(
  parameter int PRF_DEPTH = cpu_params::PRF_DEPTH,
  parameter int ARF_DEPTH = cpu_params::ARF_DEPTH,
  parameter int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  free_list_if.slave  fl
);

  localparam int FL_IDX = $clog2(FL_DEPTH);
  localparam int PW     = cpu_params::PRF_IDX;

  logic [PW-1:0] mem_q [FL_DEPTH];
  logic [PW-1:0] mem_d [FL_DEPTH];
  fl_ptr_t       head_q, head_d;
  fl_ptr_t       tail_q, tail_d;
  fl_ptr_t       tail_enq;
  logic          err_q, err_d;

  logic          empty;
  logic          full;
  logic          enq_legal;
  logic          bypass;
  logic          byp_take;
  logic          deq_take;
  logic          enq_ok;
  logic          dq_valid;

  always_comb begin
    empty     = (head_q == tail_q);
    // Same slot, opposite lap: every entry is occupied.
    full      = (head_q[FL_IDX] != tail_q[FL_IDX]) &&
                (head_q[FL_IDX-1:0] == tail_q[FL_IDX-1:0]);
    enq_legal = fl.enq_en && (fl.enq_phy != '0);
`ifdef FREE_LIST_BYPASS_EN
    bypass    = empty && enq_legal;
`else
    bypass    = 1'b0;
`endif
    dq_valid  = !empty || bypass;
    // A flushed cycle discards whatever rename tried to take.
    deq_take  = fl.dq_en && !empty && !fl.flush;
    byp_take  = bypass && fl.dq_en && !fl.flush;
    // When full, the same-cycle dequeue frees the slot tail points at; the
    // read of that slot happens before the write edge, so it returns the
    // old contents.
    enq_ok    = enq_legal && (!full || deq_take) && !byp_take;
  end

  always_comb begin
    mem_d = mem_q;
    if (enq_ok) begin
      mem_d[tail_q[FL_IDX-1:0]] = fl.enq_phy;
    end
    tail_enq = tail_q + fl_ptr_t'(enq_ok);
    tail_d   = tail_enq;
    if (fl.flush) begin
      // One full lap behind the post-enqueue tail: the list becomes full and
      // the slots dequeued but not yet overwritten by commits come back.
      head_d = {~tail_enq[FL_IDX], tail_enq[FL_IDX-1:0]};
    end else begin
      head_d = head_q + fl_ptr_t'(deq_take);
    end
    err_d = err_q
          | (fl.dq_en && !dq_valid)
          | (fl.enq_en && (fl.enq_phy == '0))
          | (enq_legal && full && !deq_take);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= PW'(ARF_DEPTH + i);
      end
      head_q <= '0;
      tail_q <= {1'b1, {FL_IDX{1'b0}}};
      err_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  assign fl.dq_valid = dq_valid;
  assign fl.dq_phy   = bypass ? fl.enq_phy : mem_q[head_q[FL_IDX-1:0]];
  assign fl.full     = full;
  assign fl.err      = err_q;

endmodule
